key_adjust_ctrl: RTL and testbench



---
 rtl/key_adjust_ctrl_pkg.sv | 26 ++
 rtl/key_adjust_ctrl_debounce.sv | 48 ++++
 rtl/key_adjust_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_key_adjust_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_adjust_ctrl_pkg.sv
// Shared types and constants for the DE2 clock key adjust controller.
package key_adjust_pkg;

  typedef enum logic {
    RUN = 1'b0,
    SET = 1'b1
  } state_t;

  localparam int unsigned K_MODE = 0;
  localparam int unsigned K_NEXT = 1;
  localparam int unsigned K_ADD  = 2;
  localparam int unsigned K_CLR  = 3;

  localparam logic [3:0] SEL_FIRST = 4'd2;
  localparam logic [3:0] SEL_LAST  = 4'd15;

  // Millisecond digits 0 and 1 are skipped on wrap.
  function automatic logic [3:0] sel_step(input logic [3:0] sel);
    return (sel == SEL_LAST) ? SEL_FIRST : sel + 4'd1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_adjust_ctrl_debounce.sv
// One raw active-low key: 2-FF synchronizer, debouncer and registered press strobe.
module key_debounce
  import key_adjust_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_down,
  output logic key_press
);

  localparam int unsigned   CW     = cnt_width(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_TC = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level_n;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      level_n   <= 1'b1;
      cnt       <= '0;
      key_press <= 1'b0;
    end else begin
      sync1     <= key_n;
      sync2     <= sync1;
      key_press <= 1'b0;
      // Any sample matching the accepted level restarts the stability count.
      if (sync2 == level_n) begin
        cnt <= '0;
      end else if (cnt == CNT_TC) begin
        cnt       <= '0;
        level_n   <= sync2;
        key_press <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign key_down = ~level_n;

endmodule

// File: rtl/key_adjust_ctrl.sv
// Turns the four DE2 keys into adjust/select/add/clr controls for the time-flow
// block, with glitch-free fixed-width add/clr pulses and a blink flag.
module key_adjust_ctrl
  import key_adjust_pkg::*;
#(
  parameter int unsigned DEB_CYCLES    = 1_000_000,
  parameter int unsigned PULSE_CYCLES  = 50_000,
  parameter int unsigned HOLD_CYCLES   = 25_000_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000,
  parameter int unsigned BLINK_CYCLES  = 12_500_000
) (
  input  logic       CLOCK_50,
  input  logic       rst_n,
  input  logic [3:0] KEY,
  output logic       adjust,
  output logic [3:0] select,
  output logic       add,
  output logic       clr,
  output logic       blink
);

  localparam int unsigned   PW       = cnt_width(PULSE_CYCLES);
  localparam int unsigned   HW       = cnt_width(HOLD_CYCLES);
  localparam int unsigned   RW       = cnt_width(REPEAT_CYCLES);
  localparam int unsigned   BW       = cnt_width(BLINK_CYCLES);
  localparam logic [PW-1:0] PULSE_TC = PW'(PULSE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_TC  = HW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REP_TC   = RW'(REPEAT_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_CYCLES - 1);

  localparam logic [1:0] P_IDLE  = 2'd0;
  localparam logic [1:0] P_HIGH  = 2'd1;
  localparam logic [1:0] P_GUARD = 2'd2;

  logic [3:0]    key_down;
  logic [3:0]    key_press;
  logic          key_down_unused;
  state_t        state;
  logic          mode_pend;
  logic          next_pend;
  logic          rep_on;
  logic [1:0]    pphase;
  logic [PW-1:0] pcnt;
  logic [HW-1:0] hcnt;
  logic [RW-1:0] rcnt;
  logic [BW-1:0] bcnt;

  logic busy;
  logic toggle;
  logic mode_go;
  logic in_set;
  logic hold_run;
  logic rep_req;
  logic next_req;
  logic start_add;
  logic start_clr;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk       (CLOCK_50),
      .rst_n     (rst_n),
      .key_n     (KEY[i]),
      .key_down  (key_down[i]),
      .key_press (key_press[i])
    );
  end

  // Only the add level drives the hold counter.
  assign key_down_unused = ^{key_down[K_MODE], key_down[K_NEXT], key_down[K_CLR]};

  always_comb begin
    busy      = (pphase != P_IDLE);
    toggle    = mode_pend ^ key_press[K_MODE];
    mode_go   = toggle && !busy;
    in_set    = (state == SET) && !mode_go;
    hold_run  = key_down[K_ADD] && (state == SET);
    rep_req   = hold_run && (rep_on ? (rcnt == REP_TC) : (hcnt == HOLD_TC));
    next_req  = next_pend || key_press[K_NEXT];
    start_clr = in_set && !busy && key_press[K_CLR];
    start_add = in_set && !busy && !key_press[K_CLR] && (key_press[K_ADD] || rep_req);
  end

  // Mode and select changes wait for an idle pulse unit; a select change is
  // also deferred past a pulse starting this cycle so select is stable around add/clr.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      mode_pend <= 1'b0;
      next_pend <= 1'b0;
      select    <= SEL_FIRST;
    end else begin
      mode_pend <= busy ? toggle : 1'b0;
      if (mode_go) begin
        state     <= (state == RUN) ? SET : RUN;
        next_pend <= 1'b0;
        if (state == RUN) begin
          select <= SEL_FIRST;
        end
      end else if (state == SET) begin
        if (busy || start_add || start_clr) begin
          next_pend <= next_req;
        end else begin
          next_pend <= 1'b0;
          if (next_req) begin
            select <= sel_step(select);
          end
        end
      end else begin
        next_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      blink <= 1'b0;
      bcnt  <= '0;
    end else if (mode_go) begin
      blink <= (state == RUN);
      bcnt  <= '0;
    end else if (state == SET) begin
      if (bcnt == BLINK_TC) begin
        blink <= ~blink;
        bcnt  <= '0;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      hcnt   <= '0;
      rcnt   <= '0;
      rep_on <= 1'b0;
    end else if (!hold_run || mode_go) begin
      hcnt   <= '0;
      rcnt   <= '0;
      rep_on <= 1'b0;
    end else if (!rep_on) begin
      if (hcnt == HOLD_TC) begin
        rep_on <= 1'b1;
        rcnt   <= '0;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end else if (rcnt == REP_TC) begin
      rcnt <= '0;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      pphase <= P_IDLE;
      pcnt   <= '0;
      add    <= 1'b0;
      clr    <= 1'b0;
    end else begin
      case (pphase)
        P_IDLE: begin
          if (start_add || start_clr) begin
            pphase <= P_HIGH;
            pcnt   <= '0;
            add    <= start_add;
            clr    <= start_clr;
          end
        end
        P_HIGH: begin
          if (pcnt == PULSE_TC) begin
            pphase <= P_GUARD;
            pcnt   <= '0;
            add    <= 1'b0;
            clr    <= 1'b0;
          end else begin
            pcnt <= pcnt + 1'b1;
          end
        end
        P_GUARD: begin
          if (pcnt == PULSE_TC) begin
            pphase <= P_IDLE;
            pcnt   <= '0;
          end else begin
            pcnt <= pcnt + 1'b1;
          end
        end
        default: begin
          pphase <= P_IDLE;
          pcnt   <= '0;
          add    <= 1'b0;
          clr    <= 1'b0;
        end
      endcase
    end
  end

  assign adjust = (state == RUN);

endmodule

// File: tb/tb_key_adjust_ctrl.sv
// Directed bench for key_adjust_ctrl with a scoreboard of expected select,
// adjust and pulse events consumed by a negedge monitor.
`timescale 1ns/1ps
module tb_key_adjust_ctrl;

  localparam int unsigned DEB    = 4;
  localparam int unsigned PULSE  = 3;
  localparam int unsigned HOLD   = 20;
  localparam int unsigned REPEAT = 8;
  localparam int unsigned BLINK  = 6;

  logic       CLOCK_50 = 1'b0;
  logic       rst_n;
  logic [3:0] KEY;
  logic       adjust;
  logic [3:0] select;
  logic       add;
  logic       clr;
  logic       blink;

  always #5 CLOCK_50 = ~CLOCK_50;

  key_adjust_ctrl #(
    .DEB_CYCLES    (DEB),
    .PULSE_CYCLES  (PULSE),
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (REPEAT),
    .BLINK_CYCLES  (BLINK)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .KEY      (KEY),
    .adjust   (adjust),
    .select   (select),
    .add      (add),
    .clr      (clr),
    .blink    (blink)
  );

  typedef struct {
    logic        kind;   // 0 = add, 1 = clr
    int unsigned width;
    int unsigned gap;    // rise-to-rise distance from previous pulse, 0 = unchecked
  } pulse_t;

  pulse_t      exp_pulse[$];
  logic [3:0]  exp_sel[$];
  logic        exp_adj[$];

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  bit          mon_en   = 1'b0;
  int unsigned cyc      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic press(input int unsigned k);
    KEY[k] = 1'b0;
    step(8);
    KEY[k] = 1'b1;
    step(8);
  endtask

  // Monitor: consumes scoreboard entries as the DUT produces events.
  logic        prev_add = 1'b0, prev_clr = 1'b0, prev_adj = 1'b1;
  logic [3:0]  prev_sel = 4'd2;
  int unsigned rise_cyc = 0, last_rise = 0, rise_gap = 0;
  pulse_t      pe;
  logic [3:0]  es;
  logic        ea;

  always @(negedge CLOCK_50) begin
    cyc++;
    if ((add && !prev_add) || (clr && !prev_clr)) begin
      rise_gap  = cyc - last_rise;
      last_rise = cyc;
      rise_cyc  = cyc;
    end
    if (mon_en) begin
      check("add_clr_exclusive", {31'd0, add & clr}, 32'd0);
      if (select !== prev_sel) begin
        if (exp_sel.size() > 0) es = exp_sel.pop_front();
        else es = 4'bx;
        check("select_step", {28'd0, select}, {28'd0, es});
      end
      if (adjust !== prev_adj) begin
        if (exp_adj.size() > 0) ea = exp_adj.pop_front();
        else ea = 1'bx;
        check("adjust_change", {31'd0, adjust}, {31'd0, ea});
      end
      if ((prev_add && !add) || (prev_clr && !clr)) begin
        if (exp_pulse.size() > 0) pe = exp_pulse.pop_front();
        else pe = '{kind: 1'bx, width: 0, gap: 0};
        check("pulse_kind", {31'd0, prev_clr}, {31'd0, pe.kind});
        check("pulse_width", cyc - rise_cyc, pe.width);
        if (pe.gap != 0) check("pulse_gap", rise_gap, pe.gap);
      end
    end
    prev_add = add;
    prev_clr = clr;
    prev_adj = adjust;
    prev_sel = select;
  end

  int unsigned lat;
  int unsigned bounce_len [6] = '{2, 1, 3, 2, 1, 1};
  logic        bounce_lvl [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    rst_n = 1'b0;
    KEY   = 4'hF;
    step(3);
    check("reset_outputs", {24'd0, adjust, select, add, clr, blink}, 32'h90);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Idle in RUN with keys released.
    for (int i = 0; i < 50; i++) begin
      step(1);
      check("idle_run", {24'd0, adjust, select, add, clr, blink}, 32'h90);
    end

    // Bouncy mode press: exactly one RUN->SET transition.
    exp_adj.push_back(1'b0);
    for (int i = 0; i < 6; i++) begin
      KEY[0] = bounce_lvl[i];
      step(bounce_len[i]);
    end
    KEY[0] = 1'b0;
    lat = 0;
    for (int w = 1; w <= 30; w++) begin
      step(1);
      if (adjust === 1'b0) begin
        lat = w;
        break;
      end
    end
    check("mode_latency", lat, DEB + 3);
    check("set_select", {28'd0, select}, 32'd2);
    for (int i = 0; i < 18; i++) begin
      check("blink_phase", {31'd0, blink}, ((i / BLINK) % 2 == 0) ? 32'd1 : 32'd0);
      step(1);
    end
    KEY[0] = 1'b1;
    step(12);

    // Fourteen next presses walk 3..15 then wrap to 2.
    for (int i = 0; i < 14; i++) begin
      exp_sel.push_back((i == 13) ? 4'd2 : 4'(3 + i));
      press(1);
    end
    check("select_wrapped", {28'd0, select}, 32'd2);

    // Single add tap.
    exp_pulse.push_back('{kind: 1'b0, width: PULSE, gap: 0});
    press(2);
    step(4);

    // Held add: first pulse, one HOLD cycles after debounced press, then every REPEAT.
    exp_pulse.push_back('{kind: 1'b0, width: PULSE, gap: 0});
    exp_pulse.push_back('{kind: 1'b0, width: PULSE, gap: HOLD - 1});
    for (int i = 0; i < 4; i++) exp_pulse.push_back('{kind: 1'b0, width: PULSE, gap: REPEAT});
    KEY[2] = 1'b0;
    step(56);
    KEY[2] = 1'b1;
    step(20);

    // Simultaneous add+clr: clr wins; a mode press during the pulse waits for idle.
    exp_pulse.push_back('{kind: 1'b1, width: PULSE, gap: 0});
    exp_adj.push_back(1'b1);
    KEY[2] = 1'b0;
    KEY[3] = 1'b0;
    step(3);
    KEY[0] = 1'b0;
    lat = 0;
    for (int w = 4; w <= 40; w++) begin
      step(1);
      if (adjust === 1'b1) begin
        lat = w;
        break;
      end
    end
    check("pending_mode_latency", lat, 32'd14);
    KEY = 4'hF;
    step(12);

    // RUN ignores add and clr keys.
    KEY[2] = 1'b0;
    KEY[3] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("run_no_pulse", {30'd0, add, clr}, 32'd0);
    end
    KEY = 4'hF;
    step(12);

    // Re-entering SET reloads select to 2.
    exp_adj.push_back(1'b0);
    press(0);
    exp_sel.push_back(4'd3);
    press(1);
    exp_adj.push_back(1'b1);
    press(0);
    exp_adj.push_back(1'b0);
    exp_sel.push_back(4'd2);
    press(0);
    exp_sel.push_back(4'd3);
    press(1);

    // Asynchronous reset truncates an add pulse in flight.
    KEY[2] = 1'b0;
    lat = 0;
    for (int w = 1; w <= 30; w++) begin
      step(1);
      if (add === 1'b1) begin
        lat = w;
        break;
      end
    end
    check("add_tap_latency", lat, DEB + 3);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {24'd0, adjust, select, add, clr, blink}, 32'h90);
    KEY = 4'hF;
    step(3);
    rst_n = 1'b1;
    step(10);
    check("post_reset_outputs", {24'd0, adjust, select, add, clr, blink}, 32'h90);

    check("pulse_queue_drained", exp_pulse.size(), 32'd0);
    check("select_queue_drained", exp_sel.size(), 32'd0);
    check("adjust_queue_drained", exp_adj.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
